// File: rtl/fish_tank_pkg.sv
// Shared types and default timing constants for the fish-tank controller blocks.
// Includes the counter width helper used by the buzzer driver and its alert filter.
package fish_tank_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } alarm_state_e;

   localparam int DEF_TONE_HALF  = 12500;
   localparam int DEF_ON_CYC     = 10_000_000;
   localparam int DEF_OFF_CYC    = 10_000_000;
   localparam int DEF_FILT_CYC   = 50_000;
   localparam int DEF_MIN_BURSTS = 3;

   // Width of a counter spanning 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/buzzer_alarm_driver_if.sv
// Pin-level bundle between the alert logic / user panel and the buzzer driver.
// Exposes the driver FSM state for observation.
interface buzzer_alarm_driver_if;
   import fish_tank_pkg::*;

   // No valid/ready handshake: alert_n is an asynchronous level, mute is a
   // one-cycle synchronous strobe that only takes effect while alarm_active is high.
   logic         alert_n;
   logic         mute;
   logic         buzz_out;
   logic         alarm_active;
   logic         muted;
   alarm_state_e state_dbg;

   modport master (
      output alert_n,
      output mute,
      input  buzz_out,
      input  alarm_active,
      input  muted,
      input  state_dbg
   );

   modport slave (
      input  alert_n,
      input  mute,
      output buzz_out,
      output alarm_active,
      output muted,
      output state_dbg
   );

endinterface

// File: rtl/alert_filter.sv
// Two-flop synchronizer plus persistence filter for the active-low gas alert.
// alert_q only follows the input after it has held a new level for FILT_CYC edges.
module alert_filter
   import fish_tank_pkg::*;
#(
   parameter int FILT_CYC = DEF_FILT_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic alert_n,
   output logic alert_q
);

   localparam int CW = cnt_w(FILT_CYC);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          alert_d;
   logic          raw;

   always_comb begin
      raw     = ~sync2_q;
      alert_d = alert_q;
      cnt_d   = '0;
      if (raw != alert_q) begin
         if (cnt_q == CW'(FILT_CYC - 1)) begin
            alert_d = raw;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Sync flops reset high so a released reset never looks like an alert.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         alert_q <= 1'b0;
      end else begin
         sync1_q <= alert_n;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         alert_q <= alert_d;
      end
   end

endmodule

// File: rtl/buzzer_alarm_driver.sv
// Drives a passive buzzer with cadenced tone bursts while a qualified gas alert
// is present, with a minimum number of bursts per episode and a panel mute.
module buzzer_alarm_driver
   import fish_tank_pkg::*;
#(
   parameter int TONE_HALF  = DEF_TONE_HALF,
   parameter int ON_CYC     = DEF_ON_CYC,
   parameter int OFF_CYC    = DEF_OFF_CYC,
   parameter int FILT_CYC   = DEF_FILT_CYC,
   parameter int MIN_BURSTS = DEF_MIN_BURSTS
) (
   input logic                   clk,
   input logic                   rst_n,
   buzzer_alarm_driver_if.slave  bus
);

   localparam int PW = cnt_w((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC);
   localparam int TW = cnt_w(TONE_HALF);
   localparam int BW = cnt_w(MIN_BURSTS + 1);

   logic alert_q;

   alert_filter #(.FILT_CYC(FILT_CYC)) u_alert_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .alert_n (bus.alert_n),
      .alert_q (alert_q)
   );

   alarm_state_e  state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [TW-1:0] tone_q, tone_d;
   logic [BW-1:0] burst_q, burst_d;
   logic          tone_lvl_q, tone_lvl_d;
   logic          muted_q, muted_d;
   logic          alarm_active_q, alarm_active_d;
   logic          buzz_q, buzz_d;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      tone_d     = tone_q;
      burst_d    = burst_q;
      tone_lvl_d = tone_lvl_q;
      muted_d    = muted_q | (bus.mute & alarm_active_q);

      case (state_q)
         IDLE: begin
            if (alert_q) begin
               state_d    = ON;
               phase_d    = '0;
               tone_d     = '0;
               burst_d    = '0;
               tone_lvl_d = 1'b1;
            end
         end
         ON: begin
            if (tone_q == TW'(TONE_HALF - 1)) begin
               tone_d     = '0;
               tone_lvl_d = ~tone_lvl_q;
            end else begin
               tone_d = tone_q + TW'(1);
            end
            if (phase_q == PW'(ON_CYC - 1)) begin
               state_d    = OFF;
               phase_d    = '0;
               tone_d     = '0;
               tone_lvl_d = 1'b0;
               if (burst_q < BW'(MIN_BURSTS)) begin
                  burst_d = burst_q + BW'(1);
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         OFF: begin
            // The continue/stop decision is made only here, so a burst is never cut short.
            if (phase_q == PW'(OFF_CYC - 1)) begin
               phase_d = '0;
               if (alert_q || (burst_q < BW'(MIN_BURSTS))) begin
                  state_d    = ON;
                  tone_d     = '0;
                  tone_lvl_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            tone_lvl_d = 1'b0;
         end
      endcase

      // Mute belongs to one episode only, and is meaningless while idle.
      if (state_d == IDLE) begin
         muted_d = 1'b0;
      end

      alarm_active_d = (state_d != IDLE);
      buzz_d         = tone_lvl_d & ~muted_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         phase_q        <= '0;
         tone_q         <= '0;
         burst_q        <= '0;
         tone_lvl_q     <= 1'b0;
         muted_q        <= 1'b0;
         alarm_active_q <= 1'b0;
         buzz_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         tone_q         <= tone_d;
         burst_q        <= burst_d;
         tone_lvl_q     <= tone_lvl_d;
         muted_q        <= muted_d;
         alarm_active_q <= alarm_active_d;
         buzz_q         <= buzz_d;
      end
   end

   assign bus.buzz_out     = buzz_q;
   assign bus.alarm_active = alarm_active_q;
   assign bus.muted        = muted_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_buzzer_alarm_driver.sv
// Directed bench for buzzer_alarm_driver with short timing parameters
// (TONE_HALF=2, ON_CYC=8, OFF_CYC=8, FILT_CYC=4, MIN_BURSTS=2).
module tb_buzzer_alarm_driver;
   import fish_tank_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   buzzer_alarm_driver_if bus ();

   buzzer_alarm_driver #(
      .TONE_HALF  (2),
      .ON_CYC     (8),
      .OFF_CYC    (8),
      .FILT_CYC   (4),
      .MIN_BURSTS (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand-derived cadence: j = cycles since burst start; 8 on (1,1,0,0,...), 8 off.
   function automatic logic exp_buzz(input int j);
      return ((j % 16) < 8) && ((j % 4) < 2);
   endfunction

   // Leaves the bench just after edge k+len-1, where edge k is the first low sample.
   task automatic start_alert(input int len);
      bus.alert_n = 1'b0;
      repeat (len) tick();
      bus.alert_n = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (bus.alarm_active && n < budget) begin
         tick();
         n++;
      end
      check_eq("idle_wait", 32'(bus.alarm_active), 32'd0);
      repeat (10) tick();
   endtask

   initial begin
      n_chk       = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      bus.alert_n = 1'b1;
      bus.mute    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_buzz",   32'(bus.buzz_out),     32'd0);
      check_eq("rst_active", 32'(bus.alarm_active), 32'd0);
      check_eq("rst_muted",  32'(bus.muted),        32'd0);
      check_eq("rst_state",  32'(bus.state_dbg),    32'(IDLE));
      rst_n = 1'b1;
      repeat (10) tick();
      check_eq("idle_state", 32'(bus.state_dbg), 32'(IDLE));

      // glitch of 3 cycles never qualifies
      start_alert(3);
      for (int i = 0; i < 20; i++) begin
         tick();
         check_eq("glitch_buzz",   32'(bus.buzz_out),     32'd0);
         check_eq("glitch_active", 32'(bus.alarm_active), 32'd0);
      end

      // sustained alert: active after edge k+6, cadence repeats
      bus.alert_n = 1'b0;
      repeat (6) tick();
      check_eq("sus_pre_active", 32'(bus.alarm_active), 32'd0);
      for (int j = 0; j < 48; j++) begin
         tick();
         check_eq("sus_buzz",   32'(bus.buzz_out),     32'(exp_buzz(j)));
         check_eq("sus_active", 32'(bus.alarm_active), 32'd1);
      end
      bus.alert_n = 1'b1;
      wait_idle(100);

      // short alert: exactly two bursts then idle
      start_alert(6);
      check_eq("short_pre_active", 32'(bus.alarm_active), 32'd0);
      for (int j = 0; j < 41; j++) begin
         tick();
         check_eq("short_buzz",   32'(bus.buzz_out),     (j < 32) ? 32'(exp_buzz(j)) : 32'd0);
         check_eq("short_active", 32'(bus.alarm_active), (j < 32) ? 32'd1 : 32'd0);
         if (j == 32) check_eq("short_state", 32'(bus.state_dbg), 32'(IDLE));
      end
      repeat (10) tick();

      // mute on the third cycle of the first burst
      start_alert(6);
      for (int j = 0; j < 41; j++) begin
         tick();
         check_eq("mute_buzz",   32'(bus.buzz_out),     (j < 3) ? 32'(exp_buzz(j)) : 32'd0);
         check_eq("mute_muted",  32'(bus.muted),        (j >= 3 && j < 32) ? 32'd1 : 32'd0);
         check_eq("mute_active", 32'(bus.alarm_active), (j < 32) ? 32'd1 : 32'd0);
         bus.mute = (j == 2);
      end
      repeat (10) tick();
      start_alert(6);
      for (int j = 0; j < 16; j++) begin
         tick();
         check_eq("unmute_buzz",  32'(bus.buzz_out), 32'(exp_buzz(j)));
         check_eq("unmute_muted", 32'(bus.muted),    32'd0);
      end
      wait_idle(100);

      // alert re-qualifies in the second gap: third burst, no idle
      start_alert(6);
      for (int j = 0; j < 48; j++) begin
         tick();
         check_eq("requal_buzz",   32'(bus.buzz_out),     32'(exp_buzz(j)));
         check_eq("requal_active", 32'(bus.alarm_active), 32'd1);
         if (j == 22) bus.alert_n = 1'b0;
      end
      bus.alert_n = 1'b1;
      wait_idle(200);

      // asynchronous reset while the tone is high
      start_alert(6);
      tick();
      check_eq("rst1_pre_buzz", 32'(bus.buzz_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst1_buzz",   32'(bus.buzz_out),     32'd0);
      check_eq("rst1_active", 32'(bus.alarm_active), 32'd0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         check_eq("rst1_post_active", 32'(bus.alarm_active), 32'd0);
         check_eq("rst1_post_buzz",   32'(bus.buzz_out),     32'd0);
      end

      // asynchronous reset while muted
      start_alert(6);
      tick();
      bus.mute = 1'b1;
      tick();
      bus.mute = 1'b0;
      check_eq("rst2_pre_muted", 32'(bus.muted), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst2_muted",  32'(bus.muted),        32'd0);
      check_eq("rst2_active", 32'(bus.alarm_active), 32'd0);
      check_eq("rst2_state",  32'(bus.state_dbg),    32'(IDLE));
      #2 rst_n = 1'b1;
      repeat (20) tick();
      check_eq("rst2_post_active", 32'(bus.alarm_active), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
